// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

  // Clear sequencer states
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Number of entries addressed by an addr_w-bit address
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port output select: busy blanking, hardwired zero entry,
// same-cycle write forwarding (port 1 over port 0), else stored value.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0] stored,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd_data
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = ZR && (rd_addr == '0);
  assign hit0    = BP && we0 && (wa0 == rd_addr);
  assign hit1    = BP && we1 && (wa1 == rd_addr);

  // Output priority: busy / zero entry, then write port 1, port 0, array
  always_comb begin
    rd_data = stored;
    if (busy || is_zero) begin
      rd_data = '0;
    end else if (hit1) begin
      rd_data = wd1;
    end else if (hit0) begin
      rd_data = wd0;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_RD combinational read ports, two
// prioritised write ports, optional bypass and hardwired-zero entry 0,
// debug tap, and a reset-started sequencer that zeroes one entry per cycle.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  input  logic                     WrEn0,
  input  logic [ADDR_W-1:0]        WrAddr0,
  input  logic [DATA_W-1:0]        WrData0,
  input  logic                     WrEn1,
  input  logic [ADDR_W-1:0]        WrAddr1,
  input  logic [DATA_W-1:0]        WrData1,
  input  logic [ADDR_W-1:0]        DbgAddr,
  output logic [DATA_W-1:0]        DbgData,
  output logic                     Busy
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam bit ZR    = (ZERO_REG != 0);
  // One bit wider than the address so the sweep counter cannot alias
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W:0]   clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic we0_ok;
  logic we1_ok;
  logic clr_en;

  // Writes only land when idle and out of reset; entry 0 is dropped when hardwired
  assign we0_ok = WrEn0 && !Busy && !Rst && !(ZR && (WrAddr0 == '0));
  assign we1_ok = WrEn1 && !Busy && !Rst && !(ZR && (WrAddr1 == '0));
  assign clr_en = (state == RF_CLEAR) && !Rst;

  // Clear sequencer: reset (re)starts the sweep, last entry returns to idle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
      Busy    <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == CLR_LAST) begin
            state <= RF_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= RF_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: sweep zeroing while clearing, else port 0 then port 1 (port 1 wins)
  always_ff @(posedge Clk) begin
    if (clr_en) begin
      mem[clr_ptr[ADDR_W-1:0]] <= '0;
    end else begin
      if (we0_ok) begin
        mem[WrAddr0] <= WrData0;
      end
      if (we1_ok) begin
        mem[WrAddr1] <= WrData1;
      end
    end
  end

  // Read ports: array lookup followed by per-port forwarding select
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    logic [DATA_W-1:0] stored_k;

    assign addr_k   = RdAddr[k*ADDR_W +: ADDR_W];
    assign stored_k = mem[addr_k];

    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_mux (
      .stored  (stored_k),
      .rd_addr (addr_k),
      .busy    (Busy),
      .we0     (we0_ok),
      .wa0     (WrAddr0),
      .wd0     (WrData0),
      .we1     (we1_ok),
      .wa1     (WrAddr1),
      .wd1     (WrData1),
      .rd_data (RdData[k*DATA_W +: DATA_W])
    );
  end

  // Debug tap: stored value only, blanked while clearing and for the zero entry
  always_comb begin
    DbgData = mem[DbgAddr];
    if (Busy || (ZR && (DbgAddr == '0))) begin
      DbgData = '0;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: instance a has bypass and three read ports, instance b
// has no bypass and two read ports; both share clock, reset and write ports.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rd_addr_a;
  logic [95:0] rd_data_a;
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_a, dbg_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .Clk(clk), .Rst(rst), .RdAddr(rd_addr_a), .RdData(rd_data_a),
    .WrEn0(we0), .WrAddr0(wa0), .WrData0(wd0),
    .WrEn1(we1), .WrAddr1(wa1), .WrData1(wd1),
    .DbgAddr(dbg_addr), .DbgData(dbg_a), .Busy(busy_a)
  );

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .Clk(clk), .Rst(rst), .RdAddr(rd_addr_b), .RdData(rd_data_b),
    .WrEn0(we0), .WrAddr0(wa0), .WrData0(wd0),
    .WrEn1(we1), .WrAddr1(wa1), .WrData1(wd1),
    .DbgAddr(dbg_addr), .DbgData(dbg_b), .Busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rda(input int k);
    return rd_data_a[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdb(input int k);
    return rd_data_b[k*32 +: 32];
  endfunction

  task automatic set_rd(input logic [4:0] a);
    rd_addr_a = {a, a, a};
    rd_addr_b = {a, a};
  endtask

  task automatic idle_wr();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Counts cycles Busy stays high after the current point, bounded
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      tick();
      cnt++;
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      chk({tag, "_a"}, dbg_a, 32'h0);
      chk({tag, "_b"}, dbg_b, 32'h0);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    idle_wr();
    set_rd(5'd0);
    dbg_addr = '0;

    // Test 1: one reset cycle, Busy high for 32 cycles
    tick();
    rst = 1'b0;
    chk("busy_after_rst", {31'b0, busy_a}, 32'h1);
    chk("busy_b_after_rst", {31'b0, busy_b}, 32'h1);
    for (int i = 0; i < 24; i++) tick();
    // Write while Busy (entry 9 already cleared) must be dropped; reads blanked
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_1234;
    set_rd(5'd9); dbg_addr = 5'd9;
    #1;
    chk("busy_rd_blank", rda(0), 32'h0);
    chk("busy_dbg_blank", dbg_a, 32'h0);
    tick();
    idle_wr();
    count_busy(cnt);
    chk("busy_len", 32'(cnt + 25), 32'd32);
    chk("busy_b_low", {31'b0, busy_b}, 32'h0);
    set_rd(5'd9); dbg_addr = 5'd9;
    #1;
    chk("busy_wr_drop_a", dbg_a, 32'h0);
    chk("busy_wr_drop_b", dbg_b, 32'h0);
    chk("busy_wr_drop_rd", rdb(0), 32'h0);
    sweep_zero("clr1");

    // Test 3: write r5 via port 0, read on all ports next cycle
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    set_rd(5'd5);
    tick();
    idle_wr();
    #1;
    for (int k = 0; k < 3; k++) chk("r5_a", rda(k), 32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) chk("r5_b", rdb(k), 32'hDEAD_BEEF);

    // Test 4: both ports to r7, port 1 wins, forwarded in the same cycle
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    rd_addr_a = {5'd5, 5'd5, 5'd7};
    rd_addr_b = {5'd5, 5'd7};
    #1;
    chk("byp_r7_a", rda(0), 32'h22);
    chk("byp_r5_a", rda(1), 32'hDEAD_BEEF);
    chk("nobyp_r7_b", rdb(0), 32'h0);
    tick();
    idle_wr();
    dbg_addr = 5'd7;
    #1;
    chk("dbg_r7_a", dbg_a, 32'h22);
    chk("dbg_r7_b", dbg_b, 32'h22);
    // Port 0 alone forwards too; debug tap is never bypassed
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h33;
    set_rd(5'd8); dbg_addr = 5'd8;
    #1;
    chk("byp0_r8_a", rda(2), 32'h33);
    chk("dbg_nobyp_r8", dbg_a, 32'h0);
    tick();
    idle_wr();

    // Test 5: writes to r0 dropped, r0 reads 0 same cycle and after
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    set_rd(5'd0); dbg_addr = 5'd0;
    #1;
    chk("r0_same_a", rda(0), 32'h0);
    tick();
    idle_wr();
    #1;
    chk("r0_after_a", rda(1), 32'h0);
    chk("r0_after_b", rdb(0), 32'h0);
    chk("r0_dbg", dbg_a, 32'h0);

    // Test 6: no-bypass instance returns pre-edge value, then the new one
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5;
    set_rd(5'd3);
    #1;
    chk("r3_old_b", rdb(0), 32'h0);
    chk("r3_byp_a", rda(0), 32'h5);
    tick();
    idle_wr();
    #1;
    chk("r3_new_b", rdb(1), 32'h5);
    chk("r3_new_a", rda(2), 32'h5);

    // Test 2: reset reasserted at clear cycle 10 restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("busy_mid", {31'b0, busy_a}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(cnt);
    chk("busy_restart_len", 32'(cnt), 32'd32);
    set_rd(5'd5);
    #1;
    chk("r5_cleared", rda(0), 32'h0);
    sweep_zero("clr2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
